// File: rtl/cromossomo_loader.sv
// cromossomo_loader: assembles a byte-streamed chromosome in a shadow register and commits it atomically.
// Ports: clk/rst (sync, active-high); load_start opens/restarts a frame; in_data/in_valid/in_ready byte
// handshake; cromossomo committed chromosome; chrom_valid commit pulse; busy frame in progress;
// error rejected-frame pulse; byte_cnt bytes accepted in the current frame.
// Optional: define CROMOSSOMO_LOADER_CRC_EN to append an XOR checksum byte checked in a CHECK state.
module cromossomo_loader #(
  parameter int CHROM_W = 483,
  parameter int NBYTES  = 61
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CHROM_W-1:0] cromossomo,
  output logic               chrom_valid,
  output logic               busy,
  output logic               error,
  output logic [5:0]         byte_cnt
);
  localparam int SW = 8 * NBYTES;
`ifdef CROMOSSOMO_LOADER_CRC_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
  logic [7:0] r_xor;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif
  state_t             r_state;
  logic [SW-1:0]      r_shadow;
  logic [SW-1:0]      w_full;
  logic [CHROM_W-1:0] r_crom;
  logic               r_ready, r_cv, r_busy, r_err;
  logic [5:0]         r_cnt;
  logic               w_xfer, w_last, w_ok;
  // The commit decision is taken on the edge that accepts the final byte, so the
  // new chromosome and its pulse are already visible during the COMMIT cycle.
  always_comb begin
    w_xfer = in_valid && r_ready && !load_start;
`ifdef CROMOSSOMO_LOADER_CRC_EN
    w_full = r_shadow;
    w_last = r_state == CHECK;
    w_ok   = ((w_full >> CHROM_W) == '0) && (in_data == r_xor);
`else
    w_full = {in_data, r_shadow[SW-9:0]};
    w_last = r_state == LOAD && r_cnt == 6'(NBYTES - 1);
    w_ok   = (w_full >> CHROM_W) == '0;
`endif
  end
  always_ff @(posedge clk)
    if (w_xfer && r_cnt < 6'(NBYTES)) r_shadow[{r_cnt, 3'b000} +: 8] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_crom  <= '0;
      r_cv    <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
`ifdef CROMOSSOMO_LOADER_CRC_EN
      r_xor   <= '0;
`endif
    end else begin
      r_cv  <= 1'b0;
      r_err <= 1'b0;
      if (load_start) begin
        r_state <= LOAD;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
        r_ready <= 1'b1;
`ifdef CROMOSSOMO_LOADER_CRC_EN
        r_xor   <= '0;
`endif
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 6'd1;
`ifdef CROMOSSOMO_LOADER_CRC_EN
        r_xor <= r_xor ^ in_data;
`endif
        if (w_last) begin
          r_state <= COMMIT;
          r_ready <= 1'b0;
          if (w_ok) begin
            r_crom <= w_full[CHROM_W-1:0];
            r_cv   <= 1'b1;
          end else r_err <= 1'b1;
        end
`ifdef CROMOSSOMO_LOADER_CRC_EN
        else if (r_cnt == 6'(NBYTES - 1)) r_state <= CHECK;
`endif
      end else if (r_state == COMMIT) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end
  end
  assign in_ready    = r_ready;
  assign cromossomo  = r_crom;
  assign chrom_valid = r_cv;
  assign busy        = r_busy;
  assign error       = r_err;
  assign byte_cnt    = r_cnt;
endmodule
